// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed byte image into memory, then releases the mips core.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing checksum byte (mismatch latches error).
module boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_CHK, S_DRAIN, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_DRAIN, S_RUN} state_t;
`endif
  state_t            r_state;
  logic [ADDR_W:0]   r_remain;
  logic [ADDR_W-1:0] r_wadr;
  logic [DATA_W-1:0] r_sum;
  logic              r_wr;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_wd;
  logic              w_acc;
  logic              w_run;
  logic [DATA_W-1:0] w_chk;
  assign w_run = r_state == S_RUN;
  assign w_acc = in_valid & in_ready;
  assign w_chk = r_sum + in_data;
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign in_ready = r_state == S_LEN || r_state == S_LOAD || r_state == S_CHK;
  assign error    = r_state == S_ERR;
`else
  assign in_ready = r_state == S_LEN || r_state == S_LOAD;
  assign error    = 1'b0;
`endif
  assign cpu_reset     = !w_run;
  assign done          = w_run;
  assign mem_write     = w_run ? cpu_memwrite  : r_wr;
  assign mem_adr       = w_run ? cpu_adr       : r_adr;
  assign mem_writedata = w_run ? cpu_writedata : r_wd;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_LEN;
      r_remain <= '0;
      r_wadr   <= '0;
      r_sum    <= '0;
      r_wr     <= 1'b0;
      r_adr    <= '0;
      r_wd     <= '0;
    end else begin
      r_wr <= 1'b0;
      if (restart) begin
        r_state  <= S_LEN;
        r_remain <= '0;
        r_wadr   <= '0;
        r_sum    <= '0;
      end else if (w_acc) begin
        case (r_state)
          S_LEN: begin
            // a zero header encodes a full 256-byte image
            r_remain <= {~|in_data, in_data};
            r_wadr   <= '0;
            r_sum    <= '0;
            r_state  <= S_LOAD;
          end
          S_LOAD: begin
            r_wr     <= 1'b1;
            r_adr    <= r_wadr;
            r_wd     <= in_data;
            r_sum    <= w_chk;
            r_remain <= r_remain - (ADDR_W+1)'(1);
            if (r_remain == (ADDR_W+1)'(1))
`ifdef BOOT_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DRAIN;
`endif
            else
              r_wadr <= r_wadr + ADDR_W'(1);
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          S_CHK: r_state <= (w_chk == '0) ? S_RUN : S_ERR;
`endif
          default: ;
        endcase
      end else if (r_state == S_DRAIN) begin
        r_state <= S_RUN;
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: random and directed streams checked every cycle against a stream-position model.
module tb_boot_loader;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  logic clk = 0, reset = 0, restart = 0, in_valid = 0, cpu_memwrite = 0;
  logic [7:0] in_data = 0, cpu_adr = 0, cpu_writedata = 0;
  logic in_ready, mem_write, cpu_reset, done, error;
  logic [7:0] mem_adr, mem_writedata;
  int passed = 0, total = 0;
  bit rand_cpu = 0;
  logic [7:0] img [256];
  logic [7:0] bmem [256];
  int nwr = 0, nwr0 = 0;
  logic [7:0] last_adr = 0, last_wd = 0;
  // model: position in the current byte stream and cycles since its final byte
  int n = 0, len = 0, sum = 0, post = -1;
  bit bad = 0, e_wr = 0, acc, run;
  int e_adr = 0, e_wd = 0;
  bit s_rst, s_rs, s_v;
  logic [7:0] s_d;

  boot_loader dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
    .cpu_writedata(cpu_writedata), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) begin
    bmem[mem_adr] <= mem_writedata;
    last_adr <= mem_adr;
    last_wd <= mem_writedata;
    nwr <= nwr + 1;
    if (mem_adr == 8'h00) nwr0 <= nwr0 + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    s_rst = reset; s_rs = restart; s_v = in_valid; s_d = in_data;
    #1;
    if (!s_rst) begin
      n = 0; len = 0; sum = 0; post = -1; bad = 0; e_wr = 0; e_adr = 0; e_wd = 0;
    end else begin
      acc = s_v && post < 0;
      e_wr = 0;
      if (s_rs) begin
        n = 0; post = -1; bad = 0;
      end else begin
        if (post >= 0 && post < 10) post++;
        if (acc) begin
          if (n == 0) begin
            len = (s_d == 0) ? 256 : int'(s_d); sum = 0;
          end else if (n <= len) begin
            e_wr = 1; e_adr = n - 1; e_wd = s_d; sum = (sum + s_d) % 256;
          end else bad = ((sum + s_d) % 256) != 0;
          n++;
          if (n == len + 1 + CHK) post = 0;
        end
      end
    end
    run = post >= (CHK ? 0 : 1) && !bad;
    chk("in_ready", in_ready, post < 0);
    chk("mem_write", mem_write, run ? cpu_memwrite : e_wr);
    chk("mem_adr", mem_adr, run ? cpu_adr : e_adr);
    chk("mem_writedata", mem_writedata, run ? cpu_writedata : e_wd);
    chk("cpu_reset", cpu_reset, !run);
    chk("done", done, run);
    chk("error", error, post >= 0 && bad);
  end

  task automatic step();
    @(negedge clk);
    if (rand_cpu) begin
      cpu_memwrite = 1'($urandom); cpu_adr = 8'($urandom); cpu_writedata = 8'($urandom);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      step(); in_valid = 0; in_data = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    if (gap > 0) idle($urandom_range(0, gap));
    step(); in_valid = 1; in_data = b;
    chk("src_ready", in_ready, 1);
  endtask

  task automatic stop_src();
    step(); in_valid = 0; in_data = 8'($urandom);
  endtask

  task automatic pulse_restart();
    step(); in_valid = 0; restart = 1;
    step(); restart = 0;
  endtask

  task automatic session(input int L, input int gap, input bit good, input int abort_at, input bit by_reset);
    int s = 0;
    send(8'(L), gap);
    for (int i = 0; i < L; i++) begin
      if (i == abort_at) begin
        step(); in_valid = 1'($urandom); in_data = 8'($urandom);
        if (by_reset) reset = 0; else restart = 1;
        step(); reset = 1; restart = 0; in_valid = 0;
        return;
      end
      s += img[i];
      send(img[i], gap);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(good ? 8'(256 - s % 256) : 8'(257 - s % 256), gap);
`endif
    stop_src();
  endtask

  initial begin
    int a0, z0;
    idle(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    step(); reset = 1;
    // three-byte image with exact release timing
    send(8'h03, 0); send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(8'hA0, 0);
    step(); in_valid = 0;
    chk("rel_cpu_reset_c1", cpu_reset, 0);
`else
    step(); in_valid = 0;
    chk("drain_cpu_reset", cpu_reset, 1);
    step();
    chk("rel_cpu_reset_t2", cpu_reset, 0);
`endif
    chk("rel_done", done, 1);
    idle(2);
    chk("mem0", bmem[0], 8'h10);
    chk("mem1", bmem[1], 8'h20);
    chk("mem2", bmem[2], 8'h30);
    // full 256-byte image
    pulse_restart();
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    a0 = nwr; z0 = nwr0;
    session(256, 0, 1, -1, 0);
    idle(3);
    chk("full_writes", nwr - a0, 256);
    chk("full_zero_writes", nwr0 - z0, 1);
    chk("full_last_adr", last_adr, 8'hFF);
    chk("full_last_wd", last_wd, 8'hFF);
    chk("full_done", done, 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    pulse_restart();
    send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h00, 0);
    stop_src();
    chk("err_error", error, 1);
    chk("err_cpu_reset", cpu_reset, 1);
    chk("err_in_ready", in_ready, 0);
    idle(3);
    chk("err_hold", error, 1);
    pulse_restart();
    chk("err_clr_error", error, 0);
    chk("err_clr_ready", in_ready, 1);
`endif
    // valid toggling with noise on in_data while invalid
    pulse_restart();
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom);
    a0 = nwr;
    begin
      int s = 0;
      send(8'h06, 0);
      for (int i = 0; i < 6; i++) begin idle(1); send(img[i], 0); s += img[i]; end
`ifdef BOOT_LOADER_CHECKSUM_EN
      idle(1); send(8'(256 - s % 256), 0);
`endif
      stop_src();
    end
    idle(3);
    chk("tog_writes", nwr - a0, 6);
    for (int i = 0; i < 6; i++) chk("tog_mem", bmem[i], img[i]);
    // async reset in the middle of a load
    pulse_restart();
    send(8'h05, 0); send(8'h11, 0); send(8'h22, 0);
    step(); in_valid = 0; reset = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_mem_adr", mem_adr, 0);
    chk("mid_rst_mem_wd", mem_writedata, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    step(); reset = 1;
    img[0] = 8'hAB;
    session(1, 0, 1, -1, 0);
    idle(3);
    chk("mid_rst_mem0", bmem[0], 8'hAB);
    // core pass-through, then restart reclaims the port
    step(); cpu_adr = 8'h40; cpu_memwrite = 1; cpu_writedata = 8'h5A;
    #1;
    chk("run_adr", mem_adr, 8'h40);
    chk("run_write", mem_write, 1);
    step(); restart = 1;
    step(); restart = 0;
    chk("rst_back_cpu_reset", cpu_reset, 1);
    chk("rst_back_write", mem_write, 0);
    cpu_memwrite = 0;
    // randomized sessions with aborts, gaps and bad checksums
    rand_cpu = 1;
    for (int k = 0; k < 40; k++) begin
      int L, ab;
      pulse_restart();
      L = $urandom_range(1, 40);
      for (int i = 0; i < L; i++) img[i] = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, L - 1) : -1;
      session(L, $urandom_range(0, 3), $urandom_range(0, 3) != 0, ab, 1'($urandom));
      idle($urandom_range(1, 6));
    end
    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
